// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite slave-side bus bundle for the register file.
// The master modport is the view of the requester; the slave modport is the view of the register file.
interface axi_lite_regfile_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  localparam int STRB_W = DATA_W / 8;

  // Write address channel
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  // Write data channel
  logic [DATA_W-1:0] s_wdata;
  logic [STRB_W-1:0] s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  // Write response channel
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  // Read address channel
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  // Read data channel
  logic [DATA_W-1:0] s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  modport master (
    output s_awaddr, s_awvalid, input s_awready,
    output s_wdata, s_wstrb, s_wvalid, input s_wready,
    input  s_bresp, s_bvalid, output s_bready,
    output s_araddr, s_arvalid, input s_arready,
    input  s_rdata, s_rresp, s_rvalid, output s_rready
  );

  modport slave (
    input  s_awaddr, s_awvalid, output s_awready,
    input  s_wdata, s_wstrb, s_wvalid, output s_wready,
    output s_bresp, s_bvalid, input s_bready,
    input  s_araddr, s_arvalid, output s_arready,
    output s_rdata, s_rresp, s_rvalid, input s_rready
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file.
// NUM_REGS word registers with byte strobes, optional read-only status slots
// (RO_MASK) that read back ro_d, decoupled 1-entry AW/W buffers, SLVERR on
// out-of-range or read-only writes, and a one-cycle write pulse per register.
module axi_lite_regfile #(
  parameter int                   ADDR_W    = 32,
  parameter int                   DATA_W    = 32,
  parameter int                   NUM_REGS  = 8,
  parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  axi_lite_regfile_if.slave            s,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  input  logic [NUM_REGS*DATA_W-1:0]   ro_d,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int         STRB_W      = DATA_W / 8;
  localparam int         OFF_W       = $clog2(STRB_W);
  localparam int         IDX_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Merge new bytes into an old word wherever the strobe bit is set.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [STRB_W-1:0] strb
  );
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      if (strb[b]) begin
        res[b*8 +: 8] = new_v[b*8 +: 8];
      end else begin
        res[b*8 +: 8] = old_v[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // True when the word index of a byte address names an implemented register.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] word_idx;
    word_idx = addr >> OFF_W;
    return (word_idx < ADDR_W'(NUM_REGS));
  endfunction

  // Register index of a byte address; only meaningful when addr_in_range holds.
  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return IDX_W'(addr >> OFF_W);
  endfunction

  // Write-side state
  logic                aw_full_q, aw_full_d;
  logic [ADDR_W-1:0]   awaddr_q,  awaddr_d;
  logic                w_full_q,  w_full_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic [STRB_W-1:0]   wstrb_q,   wstrb_d;
  logic                bvalid_q,  bvalid_d;
  logic [1:0]          bresp_q,   bresp_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  // Read-side state
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q,  rdata_d;
  logic [1:0]          rresp_q,  rresp_d;

  // Decode / handshake signals
  logic                aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic                wr_ok_s;
  logic [IDX_W-1:0]    wr_idx_s;
  logic                rd_in_range_s;
  logic [IDX_W-1:0]    rd_idx_s;
  logic [DATA_W-1:0]   rd_val_s;
  logic [1:0]          rd_resp_s;
  logic [DATA_W-1:0]   ro_arr_s [NUM_REGS];

  assign s.s_awready = !aw_full_q;
  assign s.s_wready  = !w_full_q;
  assign s.s_arready = !rvalid_q;
  assign s.s_bvalid  = bvalid_q;
  assign s.s_bresp   = bresp_q;
  assign s.s_rvalid  = rvalid_q;
  assign s.s_rdata   = rdata_q;
  assign s.s_rresp   = rresp_q;
  assign wr_pulse    = wr_pulse_q;

  assign aw_hs_s  = s.s_awvalid && !aw_full_q;
  assign w_hs_s   = s.s_wvalid  && !w_full_q;
  assign ar_hs_s  = s.s_arvalid && !rvalid_q;
  // Commit waits for both halves and for the previous response to drain.
  assign commit_s = aw_full_q && w_full_q && !bvalid_q;
  assign wr_idx_s = addr_index(awaddr_q);
  assign wr_ok_s  = addr_in_range(awaddr_q) && !RO_MASK[wr_idx_s];

  // Flatten the register array onto the export bus; RO slots are never written so they stay 0.
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  // Split the status input bus into per-register words.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      ro_arr_s[i] = ro_d[i*DATA_W +: DATA_W];
    end
  end

  // Read mux: RW regs return stored value, RO regs return live status, out-of-range returns 0.
  always_comb begin
    rd_in_range_s = addr_in_range(s.s_araddr);
    rd_idx_s      = addr_index(s.s_araddr);
    rd_val_s      = '0;
    rd_resp_s     = RESP_SLVERR;
    if (rd_in_range_s) begin
      rd_resp_s = RESP_OKAY;
      if (RO_MASK[rd_idx_s]) begin
        rd_val_s = ro_arr_s[rd_idx_s];
      end else begin
        rd_val_s = regs_q[rd_idx_s];
      end
    end else begin
      rd_val_s  = '0;
      rd_resp_s = RESP_SLVERR;
    end
  end

  // Write path next state: buffer capture, commit into the register array, response and pulse.
  always_comb begin
    aw_full_d  = aw_full_q;
    awaddr_d   = awaddr_q;
    w_full_d   = w_full_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    if (commit_s) begin
      // Both buffers are full here, so no new AW/W handshake can coincide.
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (wr_ok_s) begin
        bresp_d              = RESP_OKAY;
        regs_d[wr_idx_s]     = merge_bytes(regs_q[wr_idx_s], wdata_q, wstrb_q);
        wr_pulse_d[wr_idx_s] = 1'b1;
      end else begin
        bresp_d = RESP_SLVERR;
      end
    end else begin
      if (aw_hs_s) begin
        aw_full_d = 1'b1;
        awaddr_d  = s.s_awaddr;
      end else begin
        aw_full_d = aw_full_q;
      end
      if (w_hs_s) begin
        w_full_d = 1'b1;
        wdata_d  = s.s_wdata;
        wstrb_d  = s.s_wstrb;
      end else begin
        w_full_d = w_full_q;
      end
      if (bvalid_q && s.s_bready) begin
        bvalid_d = 1'b0;
      end else begin
        bvalid_d = bvalid_q;
      end
    end
  end

  // Read path next state: capture data on AR handshake, hold until R handshake.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs_s) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val_s;
      rresp_d  = rd_resp_s;
    end else if (rvalid_q && s.s_rready) begin
      rvalid_d = 1'b0;
    end else begin
      rvalid_d = rvalid_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full_q  <= 1'b0;
      awaddr_q   <= '0;
      w_full_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL;
      end
    end else begin
      aw_full_q  <= aw_full_d;
      awaddr_q   <= awaddr_d;
      w_full_q   <= w_full_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      wr_pulse_q <= wr_pulse_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule
